adc_sar_responder: RTL
======================

// Module: adc_sar_responder
// PURPOSE
//  ADC-side responder for the wr/intrupt/digital_data handshake driven by the ADC controller.
//  A rising edge on wr starts a successive-approximation conversion of sample_in.
//  When the conversion finishes, intrupt goes low and the result is held on digital_data.
//  Used as the synthesizable converter front end and as the bench partner for the controller.
// PARAMETERS
//  DATA_W      8  result / sample width in bits
//  BIT_CYCLES  1  clk cycles spent per SAR bit decision (>=1)
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       asynchronous, active-high reset
//  wr            in   1       conversion start; a low->high transition starts a conversion
//  sample_in     in   DATA_W  unsigned analog stand-in value
//  intrupt       out  1       active-low end-of-conversion
//  digital_data  out  DATA_W  last conversion result; held until the next conversion completes
//  busy          out  1       1 while in SAMPLE or CONVERT
//  overrun       out  1       1-cycle pulse: wr rising edge ignored because busy
// BEHAVIOUR
//  - Reset values: intrupt=1, digital_data=0, busy=0, overrun=0, state=IDLE.
//    Internal registers: wr_q=1, sar=0, sample_reg=0, bit_idx=DATA_W-1, div=0.
//    wr_q resets to 1, so wr held high through reset does not start a conversion.
//  - Edge detect: wr_q <= wr every cycle. rise = wr & ~wr_q; fall = ~wr & wr_q.
//  - States: IDLE, SAMPLE, CONVERT, DONE.
//  - IDLE: on rise -> SAMPLE (this clock edge is E0).
//  - SAMPLE: one cycle.
//    Actions: sample_reg <= sample_in, sar <= 0, bit_idx <= DATA_W-1, div <= 0.
//    Next state: CONVERT (this clock edge is E1).
//  - CONVERT: one bit is decided every BIT_CYCLES cycles.
//    While div < BIT_CYCLES-1: div++.
//    Otherwise: div <= 0; trial = sar | (1<<bit_idx); sar[bit_idx] <= (sample_reg >= trial).
//    After the bit_idx==0 decision, on the same edge:
//      digital_data <= final sar (including that bit); intrupt <= 0; state -> DONE.
//    Otherwise bit_idx--.
//  - Latency: intrupt low is first visible after edge E0 + 1 + DATA_W*BIT_CYCLES.
//    Defaults: 9 cycles after E0.
//  - DONE: intrupt stays 0 and digital_data stays stable.
//    On fall: intrupt <= 1, state -> IDLE.
//    On rise: intrupt <= 1, state -> SAMPLE; this is a new conversion, and E0 is this edge.
//  - While busy:
//    - rise is ignored; overrun=1 for exactly that cycle.
//    - fall is ignored.
//    - the conversion continues on the held sample_reg; changes on sample_in have no effect.
//  - busy = (state==SAMPLE) | (state==CONVERT). It is registered, from the state.
//  - Unsigned compare only. sar never exceeds sample_reg.
//    Result equals sample_in as captured at E1; the SAR is exact with no quantisation error.
//  - Reset mid-operation: immediate return to reset values; any partial result is discarded.
//    digital_data clears to 0.
// TESTING
//  1. Default params, sample_in=8'hA5, wr low 5 cycles then high
//     -> intrupt=0 on the 9th edge after E0, digital_data=8'hA5, busy=0.
//  2. sample_in=8'h00, then 8'hFF, in separate conversions -> digital_data=8'h00, then 8'hFF.
//     intrupt toggles 0 -> 1 on each wr fall.
//  3. sample_in=8'hA5 at E1, changed to 8'h3C one cycle later
//     -> digital_data=8'hA5, not 8'h3C.
//  4. wr pulsed low-then-high mid-CONVERT
//     -> overrun=1 for one cycle, busy stays 1, result and latency unchanged.
//  5. In DONE, wr falls -> intrupt=1 next edge, state IDLE.
//     wr rises 2 cycles later -> new conversion, intrupt low 9 cycles after that E0.
//  6. rst asserted 4 cycles into CONVERT, wr held high through release
//     -> intrupt=1, busy=0, digital_data=0 at once; no conversion until a new wr rise.
//     Also run BIT_CYCLES=3: latency 25 cycles.

Source files
------------

// File: rtl/adc_sar_responder.sv
// ADC-side SAR responder: a rising edge on wr samples sample_in and resolves it one bit at a time.
// Latency: intrupt falls 1 + DATA_W*BIT_CYCLES clk edges after the edge that accepts the wr rise.
// No backpressure: wr edges arriving while busy are dropped (rises flagged on overrun).
module adc_sar_responder #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] sample_in,
  output logic              intrupt,
  output logic [DATA_W-1:0] digital_data,
  output logic              busy,
  output logic              overrun
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DIV_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  state_t            state;
  logic              wr_q;
  logic [DATA_W-1:0] sar;
  logic [DATA_W-1:0] sample_reg;
  logic [IDX_W-1:0]  bit_idx;
  logic [DIV_W-1:0]  div;

  logic              rise;
  logic              fall;
  logic [DATA_W-1:0] trial;
  logic [DATA_W-1:0] sar_nxt;

  // wr edge detection against last cycle's wr
  always_comb begin
    rise = wr & ~wr_q;
    fall = ~wr & wr_q;
  end

  // Trial value for the current bit and the register value once that bit is decided
  always_comb begin
    trial            = sar;
    trial[bit_idx]   = 1'b1;
    sar_nxt          = sar;
    sar_nxt[bit_idx] = (sample_reg >= trial);
  end

  // Control FSM with registered outputs; busy tracks SAMPLE/CONVERT membership of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_q         <= 1'b1;
      sar          <= '0;
      sample_reg   <= '0;
      bit_idx      <= IDX_TOP;
      div          <= '0;
      intrupt      <= 1'b1;
      digital_data <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      wr_q    <= wr;
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= SAMPLE;
            busy  <= 1'b1;
          end
        end
        SAMPLE: begin
          // sample_reg is frozen from here on; later sample_in changes are invisible
          sample_reg <= sample_in;
          sar        <= '0;
          bit_idx    <= IDX_TOP;
          div        <= '0;
          state      <= CONVERT;
          overrun    <= rise;
        end
        CONVERT: begin
          overrun <= rise;
          if (div != DIV_TOP) begin
            div <= div + 1'b1;
          end else begin
            div <= '0;
            sar <= sar_nxt;
            if (bit_idx == '0) begin
              digital_data <= sar_nxt;
              intrupt      <= 1'b0;
              state        <= DONE;
              busy         <= 1'b0;
            end else begin
              bit_idx <= bit_idx - 1'b1;
            end
          end
        end
        DONE: begin
          // A rise here restarts directly; a fall acknowledges and returns to idle
          if (rise) begin
            intrupt <= 1'b1;
            state   <= SAMPLE;
            busy    <= 1'b1;
          end else if (fall) begin
            intrupt <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
